// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit counter width able to hold values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = ai - bi - bin, with borrow out.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow of a single bit position.
  always_comb begin
    d    = ai ^ bi ^ bin;
    bout = (~ai & bi) | (~ai & bin) | (bi & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first through one full-subtractor
// cell and a borrow flop, with a start/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] next_res;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic             d;
  logic             bout;

  full_subtractor u_cell (
    .ai   (a_sr[0]),
    .bi   (b_sr[0]),
    .bin  (brw),
    .d    (d),
    .bout (bout)
  );

  // Result register after this shift; written bitwise so WIDTH=1 needs no slice.
  always_comb begin
    next_res            = res_sr >> 1;
    next_res[WIDTH-1]   = d;
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          res_sr <= next_res;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          brw    <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= S_DONE;
            done   <= 1'b1;
            diff   <= next_res;
            borrow <= bout;
            ovf    <= (a_msb != b_msb) && (next_res[WIDTH-1] != a_msb);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        // S_IDLE and the unused encoding 2'd3 both behave as idle.
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0]  diff;
    logic        brw;
    logic        ovf;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       busy8, done8, borrow8, ovf8;

  logic start1 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, diff1;
  logic busy1, done1, borrow1, ovf1;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q8[$];
  exp_t q1[$];
  logic prev_done8 = 1'b0, prev_done1 = 1'b0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Result monitors: pop the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      check("done8_width", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("diff8", {24'd0, diff8}, {24'd0, e.diff});
        check("borrow8", {31'd0, borrow8}, {31'd0, e.brw});
        check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
        check("latency8", cyc, e.due);
      end
    end
    prev_done8 <= done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      check("done1_width", {31'd0, prev_done1}, 32'd0);
      if (q1.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("diff1", {31'd0, diff1}, {31'd0, e.diff[0]});
        check("borrow1", {31'd0, borrow1}, {31'd0, e.brw});
        check("ovf1", {31'd0, ovf1}, {31'd0, e.ovf});
        check("latency1", cyc, e.due);
      end
    end
    prev_done1 <= done1;
  end

  // Called at a negedge; returns at the negedge where the next accept is legal.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input bit chk_busy);
    exp_t e;
    e.diff = av - bv;
    e.brw  = (av < bv);
    e.ovf  = (av[7] != bv[7]) && (e.diff[7] != av[7]);
    e.due  = cyc + 1 + 8;
    q8.push_back(e);
    a8 = av; b8 = bv; start8 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (chk_busy) check("busy8_profile", {31'd0, busy8}, {31'd0, (i <= 9)});
    end
  endtask

  task automatic issue1(input logic av, input logic bv);
    exp_t e;
    e.diff = {7'd0, av ^ bv};
    e.brw  = (av < bv);
    e.ovf  = (av != bv) && (e.diff[0] != av);
    e.due  = cyc + 1 + 1;
    q1.push_back(e);
    a1 = av; b1 = bv; start1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      check("busy1_profile", {31'd0, busy1}, {31'd0, (i <= 2)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_diff8", {24'd0, diff8}, 32'd0);
    check("rst_borrow8", {31'd0, borrow8}, 32'd0);
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_diff1", {31'd0, diff1}, 32'd0);

    // Directed operand pairs.
    issue8(8'h05, 8'h03, 1'b1);
    issue8(8'h03, 8'h05, 1'b1);
    issue8(8'h00, 8'h00, 1'b1);
    issue8(8'h80, 8'h01, 1'b1);
    issue8(8'h7F, 8'hFF, 1'b1);

    // Start pulses during RUN (offset 3) and DONE (offset 9) are dropped.
    begin
      exp_t e;
      e.diff = 8'h0F; e.brw = 1'b0; e.ovf = 1'b0; e.due = cyc + 9;
      q8.push_back(e);
      a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        start8 = (i == 3 || i == 9);
        a8 = start8 ? 8'hFF : 8'h00;
        b8 = start8 ? 8'hFF : 8'h00;
        check("busy8_ignore", {31'd0, busy8}, {31'd0, (i <= 9)});
      end
      start8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("busy8_no_requeue", {31'd0, busy8}, 32'd0);
      end
    end

    // Reset in the middle of RUN aborts with no done pulse.
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy8", {31'd0, busy8}, 32'd0);
    check("abort_done8", {31'd0, done8}, 32'd0);
    check("abort_diff8", {24'd0, diff8}, 32'd0);
    check("abort_borrow8", {31'd0, borrow8}, 32'd0);
    check("abort_ovf8", {31'd0, ovf8}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_idle8", {31'd0, busy8}, 32'd0);
    end
    issue8(8'h20, 8'h08, 1'b1);

    // Randomized pairs issued at the minimum interval.
    for (int n = 0; n < 1000; n++) issue8(8'($urandom), 8'($urandom), 1'b0);
    for (int n = 0; n < 1000; n++) issue1(1'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    check("q8_drained", q8.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
